// File: rtl/jtframe_vuarb_pkg.sv
// Shared encodings and helpers for the multi-channel VU metering scheduler.
// Holds the FSM state codes, the thermometer map and the full-scale sample detector.
package jtframe_vuarb_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SNAP = 3'd1;
  localparam logic [2:0] S_SQL  = 3'd2;
  localparam logic [2:0] S_SQR  = 3'd3;
  localparam logic [2:0] S_ACC  = 3'd4;

  // Smearing the leading one downwards gives 2^(n+1)-1 for a leading one at bit n.
  function automatic logic [7:0] vu_map(input logic [7:0] b);
    logic [7:0] t;
    t = b;
    t = t | (t >> 1);
    t = t | (t >> 2);
    t = t | (t >> 4);
    return t;
  endfunction

  // |x| == 0x7FFF or 0x8000 covers +0x7FFF, -0x7FFF (0x8001) and -0x8000.
  function automatic logic is_full(input logic [15:0] x);
    return (x == 16'h7FFF) || (x == 16'h8000) || (x == 16'h8001);
  endfunction

endpackage

// File: rtl/jtframe_vuarb_ch.sv
// Per-channel power integrator: saturating accumulator, windowed VU latch, peak-hold counter.
// Results are registered one cycle after i_acc or i_clr; no backpressure, the parent sequences it.
module jtframe_vuarb_ch
  import jtframe_vuarb_pkg::*;
#(
  parameter int W   = 24,
  parameter int PKW = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_acc,
  input  logic        i_clr,
  input  logic        i_wend,
  input  logic        i_clip,
  input  logic [16:0] i_s,
  output logic [7:0]  o_vu,
  output logic        o_peak
);

  localparam int SW = ((W > 17) ? W : 17) + 1;

  logic [W-1:0]   r_acc;
  logic [PKW-1:0] r_pk_cnt;
  logic [7:0]     r_vu;
  logic           r_peak;

  logic [SW-1:0]  w_sum;
  logic           w_sat;
  logic [W-1:0]   w_next;

  // One spare bit above W catches the overflow that forces saturation.
  assign w_sum  = SW'(r_acc) + SW'(i_s);
  assign w_sat  = |w_sum[SW-1:W];
  assign w_next = w_sat ? {W{1'b1}} : w_sum[W-1:0];

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc    <= '0;
      r_pk_cnt <= '0;
      r_vu     <= '0;
      r_peak   <= 1'b0;
    end else if (i_acc) begin
      if (i_wend) begin
        r_vu  <= vu_map(w_next[W-1 -: 8]);
        r_acc <= '0;
      end else begin
        r_acc <= w_next;
      end
      if (w_sat || i_clip) begin
        r_peak   <= 1'b1;
        r_pk_cnt <= '0;
      end else begin
        r_pk_cnt <= r_pk_cnt + PKW'(1);
        if (&r_pk_cnt) begin
          r_peak <= 1'b0;
        end
      end
    end
  end

  assign o_vu   = r_vu;
  assign o_peak = r_peak;

endmodule

// File: rtl/jtframe_vuarb.sv
// Shares one 16x16 squarer across CH stereo channels to produce windowed VU and peak-hold flags.
// A sample takes 2+3*CH cycles; a cen arriving while busy is dropped and flagged on miss.
module jtframe_vuarb
  import jtframe_vuarb_pkg::*;
#(
  parameter int CH  = 4,
  parameter int W   = 24,
  parameter int WIN = 10,
  parameter int PKW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic [CH*16-1:0] ch_l,
  input  logic [CH*16-1:0] ch_r,
  input  logic [CH-1:0]   ch_en,
  output logic [CH*8-1:0] vu,
  output logic [CH-1:0]   peak,
  output logic            busy,
  output logic            miss
);

  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic [2:0]         r_state;
  logic [WIN-1:0]     r_wcnt;
  logic               r_wend;
  logic [CHW-1:0]     r_ch;
  logic [CH-1:0]      r_en;
  logic signed [15:0] r_l [CH];
  logic signed [15:0] r_r [CH];
  logic [15:0]        r_sq;
  logic [15:0]        r_pl;

  logic signed [15:0] w_op;
  logic signed [31:0] w_sq;
  logic               w_unused_sq;
  logic [16:0]        w_s;
  logic               w_last;
  logic               w_clip;

  // Single shared squarer: left operand in SQL, right operand in SQR.
  assign w_op        = (r_state == S_SQL) ? r_l[r_ch] : r_r[r_ch];
  assign w_sq        = 32'(w_op) * 32'(w_op);
  assign w_unused_sq = ^{w_sq[31], w_sq[14:0]};
  assign w_s         = {1'b0, r_pl} + {1'b0, r_sq};
  assign w_last      = (r_ch == CHW'(CH - 1));
  assign w_clip      = is_full(r_l[r_ch]) || is_full(r_r[r_ch]);

  assign busy = (r_state != S_IDLE);
  assign miss = cen && busy && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_wend  <= 1'b0;
      r_ch    <= '0;
      r_en    <= '0;
      r_sq    <= '0;
      r_pl    <= '0;
      for (int k = 0; k < CH; k++) begin
        r_l[k] <= '0;
        r_r[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cen) begin
            r_state <= S_SNAP;
          end
        end
        S_SNAP: begin
          for (int k = 0; k < CH; k++) begin
            r_l[k] <= ch_l[16*k +: 16];
            r_r[k] <= ch_r[16*k +: 16];
          end
          r_en    <= ch_en;
          r_wend  <= &r_wcnt;
          r_wcnt  <= r_wcnt + WIN'(1);
          r_ch    <= '0;
          r_state <= S_SQL;
        end
        S_SQL: begin
          // A disabled channel is cleared by its slice this cycle and costs one slot.
          if (!r_en[r_ch]) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_ch    <= r_ch + CHW'(1);
              r_state <= S_SQL;
            end
          end else begin
            r_sq    <= w_sq[30:15];
            r_state <= S_SQR;
          end
        end
        S_SQR: begin
          r_pl    <= r_sq;
          r_sq    <= w_sq[30:15];
          r_state <= S_ACC;
        end
        S_ACC: begin
          if (w_last) begin
            r_state <= S_IDLE;
          end else begin
            r_ch    <= r_ch + CHW'(1);
            r_state <= S_SQL;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic w_sel;
    assign w_sel = (r_ch == CHW'(k));

    jtframe_vuarb_ch #(
      .W   (W),
      .PKW (PKW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_acc  (w_sel && (r_state == S_ACC)),
      .i_clr  (w_sel && (r_state == S_SQL) && !r_en[k]),
      .i_wend (r_wend),
      .i_clip (w_clip),
      .i_s    (w_s),
      .o_vu   (vu[8*k +: 8]),
      .o_peak (peak[k])
    );
  end

endmodule

// File: tb/tb_jtframe_vuarb.sv
// Directed bench for jtframe_vuarb with a per-sample schedule model checked every cycle.
// Small window and peak-hold sizes keep window ends, saturation and hold expiry reachable.
module tb_jtframe_vuarb;

  localparam int CH  = 4;
  localparam int W   = 19;
  localparam int WIN = 4;
  localparam int PKW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cen = 1'b0;
  logic [CH*16-1:0] ch_l = '0;
  logic [CH*16-1:0] ch_r = '0;
  logic [CH-1:0]    ch_en = '1;
  logic [CH*8-1:0]  vu;
  logic [CH-1:0]    peak;
  logic             busy;
  logic             miss;

  always #5 clk = ~clk;

  jtframe_vuarb #(
    .CH  (CH),
    .W   (W),
    .WIN (WIN),
    .PKW (PKW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .ch_l  (ch_l),
    .ch_r  (ch_r),
    .ch_en (ch_en),
    .vu    (vu),
    .peak  (peak),
    .busy  (busy),
    .miss  (miss)
  );

  int  total = 0;
  int  bad   = 0;
  bit  chk_on = 1'b0;

  // Model: true per-channel state plus the values visible on the outputs.
  int         mcyc   = 0;
  int         busy_s = 1;
  int         busy_e = 0;
  int         mwcnt  = 0;
  longint     macc [CH];
  int         mcnt [CH];
  bit         mpk  [CH];
  logic [7:0] mvu  [CH];
  logic [7:0] ovu  [CH];
  bit         opk  [CH];
  int         up_cyc [CH];
  bit         up_v   [CH];
  logic [7:0] up_vu  [CH];
  bit         up_pk  [CH];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, mcyc);
    end
  endtask

  function automatic logic [7:0] vu_ref(input longint b);
    int n;
    n = 0;
    while ((longint'(1) << n) <= b) n++;
    return 8'((1 << n) - 1);
  endfunction

  function automatic bit full_scale(input logic signed [15:0] x);
    int a;
    a = (x < 0) ? -int'(x) : int'(x);
    return (a == 32767) || (a == 32768);
  endfunction

  task automatic model_reset();
    mwcnt  = 0;
    busy_s = 1;
    busy_e = 0;
    for (int k = 0; k < CH; k++) begin
      macc[k] = 0;
      mcnt[k] = 0;
      mpk[k]  = 1'b0;
      mvu[k]  = '0;
      ovu[k]  = '0;
      opk[k]  = 1'b0;
      up_v[k] = 1'b0;
    end
  endtask

  // Sample accepted in cycle t: compute each channel's new result and when it shows up.
  task automatic model_accept(input int t);
    int                 pos;
    longint             s, sum, mx;
    logic signed [15:0] l, r;
    bit                 wend, sat, clip;
    mx    = (longint'(1) << W) - 1;
    wend  = (mwcnt == (1 << WIN) - 1);
    mwcnt = (mwcnt + 1) % (1 << WIN);
    pos    = t + 1;
    busy_s = t + 1;
    for (int k = 0; k < CH; k++) begin
      l = ch_l[16*k +: 16];
      r = ch_r[16*k +: 16];
      if (!ch_en[k]) begin
        pos += 1;
        macc[k] = 0;
        mcnt[k] = 0;
        mpk[k]  = 1'b0;
        mvu[k]  = '0;
      end else begin
        pos += 3;
        s   = ((longint'(l) * longint'(l)) >>> 15) + ((longint'(r) * longint'(r)) >>> 15);
        sum = macc[k] + s;
        sat = (sum > mx);
        if (sat) sum = mx;
        if (wend) begin
          mvu[k]  = vu_ref(sum >> (W - 8));
          macc[k] = 0;
        end else begin
          macc[k] = sum;
        end
        clip = full_scale(l) || full_scale(r);
        if (sat || clip) begin
          mpk[k]  = 1'b1;
          mcnt[k] = 0;
        end else begin
          if (mcnt[k] == (1 << PKW) - 1) mpk[k] = 1'b0;
          mcnt[k] = (mcnt[k] + 1) % (1 << PKW);
        end
      end
      up_cyc[k] = pos + 1;
      up_v[k]   = 1'b1;
      up_vu[k]  = mvu[k];
      up_pk[k]  = mpk[k];
    end
    busy_e = pos;
  endtask

  always @(negedge clk) begin
    logic [CH*8-1:0] ev;
    logic [CH-1:0]   ep;
    bit              eb;
    mcyc++;
    for (int k = 0; k < CH; k++) begin
      if (up_v[k] && (up_cyc[k] <= mcyc)) begin
        ovu[k]  = up_vu[k];
        opk[k]  = up_pk[k];
        up_v[k] = 1'b0;
      end
    end
    eb = (mcyc >= busy_s) && (mcyc <= busy_e);
    if (chk_on) begin
      for (int k = 0; k < CH; k++) begin
        ev[8*k +: 8] = ovu[k];
        ep[k]        = opk[k];
      end
      check("cyc_busy", busy, eb);
      check("cyc_miss", miss, cen && eb && !rst);
      check("cyc_vu", vu, ev);
      check("cyc_peak", peak, ep);
    end
    if (rst) model_reset();
    else if (cen && !eb) model_accept(mcyc);
  end

  task automatic set_ch(input int k, input logic [15:0] l, input logic [15:0] r);
    ch_l[16*k +: 16] = l;
    ch_r[16*k +: 16] = r;
  endtask

  // One cen pulse, then 19 idle cycles; returns how many of them had busy high.
  task automatic do_sample(output int blen);
    blen = 0;
    @(posedge clk); #1 cen = 1'b1;
    @(posedge clk); #1 cen = 1'b0;
    for (int n = 0; n < 19; n++) begin
      @(negedge clk);
      if (busy) blen++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int blen;
    repeat (3) @(posedge clk);
    #1 chk_on = 1'b1;
    @(negedge clk);
    check("rst_vu", vu, 0);
    check("rst_peak", peak, 0);
    check("rst_busy", busy, 0);
    check("rst_miss", miss, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Moderate level on ch0: 1024 per sample, 16384 at window end -> 0x0F.
    set_ch(0, 16'h1000, 16'h1000);
    repeat (16) do_sample(blen);
    @(negedge clk);
    check("b_busy_len", blen, 13);
    check("b_vu0", vu[7:0], 'h0F);
    check("b_mdl_vu0", ovu[0], 'h0F);
    check("b_vu1", vu[15:8], 0);
    check("b_peak", peak, 0);

    // Full-scale negative on ch1: clips every sample, saturates on the 8th.
    set_ch(0, 16'h0000, 16'h0000);
    set_ch(1, 16'h8000, 16'h8000);
    repeat (16) do_sample(blen);
    @(negedge clk);
    check("c_vu1", vu[15:8], 'hFF);
    check("c_mdl_vu1", ovu[1], 'hFF);
    check("c_peak1", peak[1], 1);
    check("c_vu0", vu[7:0], 0);

    // Clipping stops: peak survives 15 quiet samples, drops on the 16th.
    set_ch(1, 16'h0000, 16'h0000);
    repeat (15) do_sample(blen);
    @(negedge clk);
    check("t_peak1_held", peak[1], 1);
    check("t_vu1_held", vu[15:8], 'hFF);
    do_sample(blen);
    @(negedge clk);
    check("t_peak1_clr", peak[1], 0);
    check("t_mdl_peak1", opk[1], 0);
    check("t_vu1_clr", vu[15:8], 0);

    // cen 5 cycles after the previous one is dropped and must not advance the window.
    set_ch(2, 16'h1000, 16'h1000);
    @(posedge clk); #1 cen = 1'b1;
    @(posedge clk); #1 cen = 1'b0;
    repeat (4) @(posedge clk);
    #1 cen = 1'b1;
    @(negedge clk);
    check("d_miss", miss, 1);
    @(posedge clk); #1 cen = 1'b0;
    @(negedge clk);
    check("d_miss_off", miss, 0);
    repeat (16) @(posedge clk);
    #1;
    repeat (14) do_sample(blen);
    @(negedge clk);
    check("d_vu2_pre", vu[23:16], 0);
    do_sample(blen);
    @(negedge clk);
    check("d_vu2", vu[23:16], 'h0F);

    // Disabling ch1 clears its held peak and shortens the sequence to 11 cycles.
    set_ch(1, 16'h8000, 16'h0000);
    do_sample(blen);
    @(negedge clk);
    check("e_peak1_pre", peak[1], 1);
    ch_en = 4'b1101;
    set_ch(1, 16'h4000, 16'h4000);
    do_sample(blen);
    @(negedge clk);
    check("e_busy_len", blen, 11);
    check("e_vu1", vu[15:8], 0);
    check("e_peak1", peak[1], 0);

    // Reset during ch2 SQR with a coincident cen: reset wins, everything clears.
    ch_en = '1;
    set_ch(0, 16'h8000, 16'h8000);
    set_ch(1, 16'h0000, 16'h0000);
    @(posedge clk); #1 cen = 1'b1;
    @(posedge clk); #1 cen = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    cen = 1'b1;
    @(negedge clk);
    check("f_busy_pre", busy, 1);
    check("f_miss_rst", miss, 0);
    check("f_peak0_pre", peak[0], 1);
    @(posedge clk); #1 rst = 1'b0;
    cen = 1'b0;
    @(negedge clk);
    check("f_busy", busy, 0);
    check("f_vu", vu, 0);
    check("f_peak", peak, 0);
    repeat (3) @(posedge clk);
    #1;
    do_sample(blen);
    @(negedge clk);
    check("f_busy_len", blen, 13);
    check("f_peak0", peak[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
